// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the memory port arbiter: FSM state encoding,
// grant-owner encoding, default widths/latency and the tie-break helper
// used when round-robin priority is enabled (MEMARB_RR_EN).
package mem_port_arbiter_pkg;

  localparam int DEFAULT_WAIT_CYCLES = 2;
  localparam int DEFAULT_ADDR_W      = 32;
  localparam int DEFAULT_DATA_W      = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // On a tie, the port that was not served most recently wins.
  function automatic owner_e rr_winner(input owner_e last_served);
    return (last_served == OWN_I) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// wait_counter
// Loadable down-counter that times the memory access latency.
// Ports:
//   clk, reset  - clock and synchronous active-high reset (clears count)
//   load        - load load_value (takes priority over dec)
//   load_value  - value loaded at the start of an access
//   dec         - decrement by one; saturates at zero
//   count       - current count
//   zero        - high while count is zero
module wait_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: load wins over decrement, and decrement stops at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported, fixed-latency memory between the instruction
// fetch port (I) and the data port (D). Each access runs IDLE -> BUSY x
// WAIT_CYCLES -> DONE, so the owner's Ready pulses WAIT_CYCLES+1 cycles
// after its request is seen in IDLE.
// Ports:
//   CLK, Reset                 - clock, synchronous active-high reset
//   IReq/IAddr                 - fetch request and address
//   IRData/IReady/IStall       - fetch data, completion pulse, stall
//   DReq/DWrite/DAddr/DWData   - data request, store flag, address, store data
//   DRData/DReady/DStall       - load data, completion pulse, stall
//   MemAddr/MemWData/MemRE/MemWE/MemRData - memory side
// Configuration:
//   MEMARB_RR_EN - when defined, simultaneous requests are resolved
//                  round-robin (last-served register resets to I, so D wins
//                  the first tie); otherwise D always beats I.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int DATA_W      = DEFAULT_DATA_W
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  output logic [DATA_W-1:0] IRData,
  output logic              IReady,
  output logic              IStall,
  input  logic              DReq,
  input  logic              DWrite,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [DATA_W-1:0] DWData,
  output logic [DATA_W-1:0] DRData,
  output logic              DReady,
  output logic              DStall,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  output logic              MemRE,
  output logic              MemWE,
  input  logic [DATA_W-1:0] MemRData
);

  localparam int               CNT_W    = $clog2(WAIT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic             WE_FIRST = (WAIT_CYCLES == 1);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic              cnt_load;
  logic              cnt_dec;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_zero;

  owner_e            tie_winner;
  owner_e            winner;
  logic              grant;
  logic              grant_write;

  wait_counter #(
    .WIDTH (CNT_W)
  ) u_wait_counter (
    .clk        (CLK),
    .reset      (Reset),
    .load       (cnt_load),
    .load_value (CNT_LOAD),
    .dec        (cnt_dec),
    .count      (cnt_val),
    .zero       (cnt_zero)
  );

`ifdef MEMARB_RR_EN
  owner_e last_served_q, last_served_d;

  assign tie_winner = rr_winner(last_served_q);

  always_comb begin
    last_served_d = last_served_q;
    if (grant) begin
      last_served_d = winner;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      last_served_q <= OWN_I;
    end else begin
      last_served_q <= last_served_d;
    end
  end
`else
  assign tie_winner = OWN_D;
`endif

  // Port selection for a new access; only meaningful while granting.
  always_comb begin
    if (IReq && DReq) begin
      winner = tie_winner;
    end else if (DReq) begin
      winner = OWN_D;
    end else begin
      winner = OWN_I;
    end
  end

  assign grant       = (state_q == ST_IDLE) && (IReq || DReq);
  assign grant_write = (winner == OWN_D) && DWrite;

  // Next-state and registered-output logic. Mem* outputs are set up one
  // cycle ahead so they are flop outputs while the FSM sits in BUSY; the
  // write strobe lands in the cycle where the counter reads zero.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    write_d     = write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (grant) begin
          owner_d     = winner;
          write_d     = grant_write;
          mem_addr_d  = (winner == OWN_D) ? DAddr : IAddr;
          mem_wdata_d = grant_write ? DWData : '0;
          mem_re_d    = !grant_write;
          mem_we_d    = grant_write && WE_FIRST;
          cnt_load    = 1'b1;
          state_d     = ST_BUSY;
        end
      end

      ST_BUSY: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          if (!write_q) begin
            if (owner_q == OWN_D) begin
              d_rdata_d = MemRData;
            end else begin
              i_rdata_d = MemRData;
            end
          end
          i_ready_d   = (owner_q == OWN_I);
          d_ready_d   = (owner_q == OWN_D);
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          state_d     = ST_DONE;
        end else begin
          mem_re_d = !write_q;
          mem_we_d = write_q && (cnt_val == CNT_ONE);
        end
      end

      ST_DONE: begin
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        state_d     = ST_IDLE;
      end

      default: begin
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_D;
      write_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      write_q     <= write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign IRData   = i_rdata_q;
  assign IReady   = i_ready_q;
  assign IStall   = IReq & ~i_ready_q;
  assign DRData   = d_rdata_q;
  assign DReady   = d_ready_q;
  assign DStall   = DReq & ~d_ready_q;
  assign MemAddr  = mem_addr_q;
  assign MemWData = mem_wdata_q;
  assign MemRE    = mem_re_q;
  assign MemWE    = mem_we_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter with WAIT_CYCLES=2: directed
// scenarios followed by randomized traffic compared against a
// transaction-level reference model. Honours MEMARB_RR_EN.
module tb_mem_port_arbiter;

  localparam int W = 2;

  logic        CLK;
  logic        Reset;
  logic        IReq;
  logic [31:0] IAddr;
  logic [31:0] IRData;
  logic        IReady;
  logic        IStall;
  logic        DReq;
  logic        DWrite;
  logic [31:0] DAddr;
  logic [31:0] DWData;
  logic [31:0] DRData;
  logic        DReady;
  logic        DStall;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic        MemRE;
  logic        MemWE;
  logic [31:0] MemRData;

  int n_checks;
  int n_pass;

  // Memory device model, written by the DUT's strobe or by bench preloads.
  logic [31:0] dev_mem [1024];
  logic [31:0] ref_mem [1024];
  logic        pre_we;
  logic        pre_clr;
  logic [31:0] pre_addr;
  logic [31:0] pre_data;

  mem_port_arbiter #(
    .WAIT_CYCLES (W),
    .ADDR_W      (32),
    .DATA_W      (32)
  ) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .IReq     (IReq),
    .IAddr    (IAddr),
    .IRData   (IRData),
    .IReady   (IReady),
    .IStall   (IStall),
    .DReq     (DReq),
    .DWrite   (DWrite),
    .DAddr    (DAddr),
    .DWData   (DWData),
    .DRData   (DRData),
    .DReady   (DReady),
    .DStall   (DStall),
    .MemAddr  (MemAddr),
    .MemWData (MemWData),
    .MemRE    (MemRE),
    .MemWE    (MemWE),
    .MemRData (MemRData)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) begin
    if (pre_clr) begin
      for (int i = 0; i < 1024; i++) dev_mem[i] <= 32'h0;
    end else begin
      if (MemWE) dev_mem[MemAddr[11:2]] <= MemWData;
      if (pre_we) dev_mem[pre_addr[11:2]] <= pre_data;
    end
  end

  // Read data is only meaningful while the arbiter is reading.
  assign MemRData = MemRE ? dev_mem[MemAddr[11:2]] : 32'hA5A5A5A5;

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    IReq = 1'b0;
    DReq = 1'b0;
    repeat (5) next_cycle();
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    next_cycle();
    pre_we   = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int idx;
    idx = 512 + int'($urandom_range(0, 15));
    return 32'(idx) << 2;
  endfunction

  task automatic test_reset();
    Reset = 1'b1;
    IReq  = 1'b1;
    DReq  = 1'b0;
    next_cycle();
    pre_clr = 1'b0;
    next_cycle();
    @(negedge CLK);
    n_checks++; if (IReady !== 1'b0) $display("[TB] FAIL reset_iready got %b want 0", IReady); else n_pass++;
    n_checks++; if (DReady !== 1'b0) $display("[TB] FAIL reset_dready got %b want 0", DReady); else n_pass++;
    n_checks++; if (MemRE !== 1'b0) $display("[TB] FAIL reset_memre got %b want 0", MemRE); else n_pass++;
    n_checks++; if (MemWE !== 1'b0) $display("[TB] FAIL reset_memwe got %b want 0", MemWE); else n_pass++;
    n_checks++; if (MemAddr !== 32'h0) $display("[TB] FAIL reset_memaddr got %h want 0", MemAddr); else n_pass++;
    n_checks++; if (MemWData !== 32'h0) $display("[TB] FAIL reset_memwdata got %h want 0", MemWData); else n_pass++;
    n_checks++; if (IRData !== 32'h0) $display("[TB] FAIL reset_irdata got %h want 0", IRData); else n_pass++;
    n_checks++; if (DRData !== 32'h0) $display("[TB] FAIL reset_drdata got %h want 0", DRData); else n_pass++;
    n_checks++; if (IStall !== 1'b1) $display("[TB] FAIL reset_istall got %b want 1", IStall); else n_pass++;
    n_checks++; if (DStall !== 1'b0) $display("[TB] FAIL reset_dstall got %b want 0", DStall); else n_pass++;
    DReq = 1'b1;
    #1;
    n_checks++; if (DStall !== 1'b1) $display("[TB] FAIL reset_dstall_follow got %b want 1", DStall); else n_pass++;
    IReq = 1'b0;
    DReq = 1'b0;
    next_cycle();
    Reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_fetch();
    settle();
    preload(32'h40, 32'h8C010004);
    IReq  = 1'b1;
    IAddr = 32'h40;
    for (int k = 0; k <= 4; k++) begin
      @(negedge CLK);
      n_checks++; if (IReady !== (k == 3)) $display("[TB] FAIL fetch_iready k=%0d got %b want %b", k, IReady, (k == 3)); else n_pass++;
      n_checks++; if (IStall !== (k < 3)) $display("[TB] FAIL fetch_istall k=%0d got %b want %b", k, IStall, (k < 3)); else n_pass++;
      if (k == 3) begin
        n_checks++; if (IRData !== 32'h8C010004) $display("[TB] FAIL fetch_irdata got %h want 8c010004", IRData); else n_pass++;
      end
      next_cycle();
      if (k == 3) IReq = 1'b0;
    end
  endtask

  task automatic test_store();
    settle();
    DReq   = 1'b1;
    DWrite = 1'b1;
    DAddr  = 32'h100;
    DWData = 32'hDEADBEEF;
    for (int k = 0; k <= 4; k++) begin
      @(negedge CLK);
      n_checks++; if (MemWE !== (k == 2)) $display("[TB] FAIL store_memwe k=%0d got %b want %b", k, MemWE, (k == 2)); else n_pass++;
      n_checks++; if (MemRE !== 1'b0) $display("[TB] FAIL store_memre k=%0d got %b want 0", k, MemRE); else n_pass++;
      n_checks++; if (DReady !== (k == 3)) $display("[TB] FAIL store_dready k=%0d got %b want %b", k, DReady, (k == 3)); else n_pass++;
      if (k == 2) begin
        n_checks++; if (MemAddr !== 32'h100) $display("[TB] FAIL store_memaddr got %h want 100", MemAddr); else n_pass++;
        n_checks++; if (MemWData !== 32'hDEADBEEF) $display("[TB] FAIL store_memwdata got %h want deadbeef", MemWData); else n_pass++;
      end
      next_cycle();
      if (k == 3) DReq = 1'b0;
    end
    n_checks++; if (dev_mem[32'h40] !== 32'hDEADBEEF) $display("[TB] FAIL store_memcontent got %h want deadbeef", dev_mem[32'h40]); else n_pass++;
  endtask

  task automatic test_tie();
    int i_rdy, d_rdy1, d_rdy2;
`ifdef MEMARB_RR_EN
    i_rdy  = 7;
    d_rdy1 = 3;
    d_rdy2 = 11;
`else
    i_rdy  = 11;
    d_rdy1 = 3;
    d_rdy2 = 7;
`endif
    settle();
    preload(32'h80, 32'h11112222);
    preload(32'h84, 32'h33334444);
    Reset = 1'b1;
    next_cycle();
    Reset  = 1'b0;
    IReq   = 1'b1;
    IAddr  = 32'h80;
    DReq   = 1'b1;
    DWrite = 1'b0;
    DAddr  = 32'h84;
    for (int k = 0; k <= 12; k++) begin
      @(negedge CLK);
      n_checks++; if (IReady !== (k == i_rdy)) $display("[TB] FAIL tie_iready k=%0d got %b want %b", k, IReady, (k == i_rdy)); else n_pass++;
      n_checks++; if (DReady !== (k == d_rdy1 || k == d_rdy2)) $display("[TB] FAIL tie_dready k=%0d got %b want %b", k, DReady, (k == d_rdy1 || k == d_rdy2)); else n_pass++;
      if (k == i_rdy) begin
        n_checks++; if (IRData !== 32'h11112222) $display("[TB] FAIL tie_irdata got %h want 11112222", IRData); else n_pass++;
      end
      if (k == d_rdy1) begin
        n_checks++; if (DRData !== 32'h33334444) $display("[TB] FAIL tie_drdata got %h want 33334444", DRData); else n_pass++;
      end
      next_cycle();
      if (k == i_rdy) IReq = 1'b0;
      if (k == d_rdy2) DReq = 1'b0;
    end
  endtask

  task automatic test_load_use();
    settle();
    preload(32'h200, 32'h12345678);
    DReq   = 1'b1;
    DWrite = 1'b0;
    DAddr  = 32'h200;
    for (int k = 0; k <= 4; k++) begin
      @(negedge CLK);
      n_checks++; if (DReady !== (k == 3)) $display("[TB] FAIL load_dready k=%0d got %b want %b", k, DReady, (k == 3)); else n_pass++;
      if (k >= 3) begin
        n_checks++; if (DRData !== 32'h12345678) $display("[TB] FAIL load_drdata k=%0d got %h want 12345678", k, DRData); else n_pass++;
      end
      next_cycle();
      if (k == 3) DReq = 1'b0;
    end
    DReq   = 1'b1;
    DWrite = 1'b1;
    DAddr  = 32'h104;
    DWData = 32'h0BADF00D;
    for (int k = 0; k <= 4; k++) begin
      @(negedge CLK);
      n_checks++; if (DReady !== (k == 3)) $display("[TB] FAIL store2_dready k=%0d got %b want %b", k, DReady, (k == 3)); else n_pass++;
      n_checks++; if (DRData !== 32'h12345678) $display("[TB] FAIL store2_drdata_held k=%0d got %h want 12345678", k, DRData); else n_pass++;
      next_cycle();
      if (k == 3) DReq = 1'b0;
    end
  endtask

  task automatic test_reset_mid_write();
    settle();
    DReq   = 1'b1;
    DWrite = 1'b1;
    DAddr  = 32'h108;
    DWData = 32'hCAFEF00D;
    for (int k = 0; k <= 6; k++) begin
      @(negedge CLK);
      n_checks++; if (MemWE !== (k == 4)) $display("[TB] FAIL rstw_memwe k=%0d got %b want %b", k, MemWE, (k == 4)); else n_pass++;
      n_checks++; if (DReady !== (k == 5)) $display("[TB] FAIL rstw_dready k=%0d got %b want %b", k, DReady, (k == 5)); else n_pass++;
      if (k == 2) begin
        n_checks++; if (MemRE !== 1'b0) $display("[TB] FAIL rstw_memre got %b want 0", MemRE); else n_pass++;
        n_checks++; if (MemAddr !== 32'h0) $display("[TB] FAIL rstw_memaddr got %h want 0", MemAddr); else n_pass++;
        n_checks++; if (DRData !== 32'h0) $display("[TB] FAIL rstw_drdata got %h want 0", DRData); else n_pass++;
        n_checks++; if (DStall !== 1'b1) $display("[TB] FAIL rstw_dstall got %b want 1", DStall); else n_pass++;
      end
      next_cycle();
      if (k == 0) Reset = 1'b1;
      if (k == 1) Reset = 1'b0;
      if (k == 5) DReq = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    settle();
    preload(32'h44, 32'h5A5A0001);
    IReq  = 1'b1;
    IAddr = 32'h44;
    for (int k = 0; k <= 8; k++) begin
      @(negedge CLK);
      n_checks++; if (IReady !== (k == 3 || k == 7)) $display("[TB] FAIL b2b_iready k=%0d got %b want %b", k, IReady, (k == 3 || k == 7)); else n_pass++;
      next_cycle();
      if (k == 7) IReq = 1'b0;
    end
  endtask

  // Transaction-level model: an access granted in cycle g occupies the
  // memory in cycles g+1..g+W, completes at g+W+1, and the arbiter is free
  // to grant again from g+W+2.
  task automatic test_random();
    int          m_grant;
    bit          m_own;
    bit          m_wr;
    bit          m_last;
    logic [31:0] m_addr, m_wdata, m_ir, m_dr;
    int          rel;
    bit          busy, done_c, e_ir, e_dr, e_re, e_we;
    logic [31:0] e_addr, e_wdata;
    settle();
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    Reset = 1'b1;
    next_cycle();
    Reset   = 1'b0;
    m_grant = -1;
    m_own   = 1'b0;
    m_wr    = 1'b0;
    m_last  = 1'b0;
    m_addr  = 32'h0;
    m_wdata = 32'h0;
    m_ir    = 32'h0;
    m_dr    = 32'h0;
    for (int c = 0; c < 600; c++) begin
      @(negedge CLK);
      rel     = (m_grant >= 0) ? (c - m_grant) : -1;
      busy    = (rel >= 1) && (rel <= W);
      done_c  = (rel == W + 1);
      e_re    = busy && !m_wr;
      e_we    = busy && m_wr && (rel == W);
      e_addr  = busy ? m_addr : 32'h0;
      e_wdata = (busy && m_wr) ? m_wdata : 32'h0;
      e_ir    = done_c && !m_own;
      e_dr    = done_c && m_own;
      if (done_c && !m_wr) begin
        if (m_own) m_dr = ref_mem[m_addr[11:2]];
        else       m_ir = ref_mem[m_addr[11:2]];
      end
      n_checks++; if (IReady !== e_ir) $display("[TB] FAIL rnd_iready c=%0d got %b want %b", c, IReady, e_ir); else n_pass++;
      n_checks++; if (DReady !== e_dr) $display("[TB] FAIL rnd_dready c=%0d got %b want %b", c, DReady, e_dr); else n_pass++;
      n_checks++; if (MemRE !== e_re) $display("[TB] FAIL rnd_memre c=%0d got %b want %b", c, MemRE, e_re); else n_pass++;
      n_checks++; if (MemWE !== e_we) $display("[TB] FAIL rnd_memwe c=%0d got %b want %b", c, MemWE, e_we); else n_pass++;
      n_checks++; if (MemAddr !== e_addr) $display("[TB] FAIL rnd_memaddr c=%0d got %h want %h", c, MemAddr, e_addr); else n_pass++;
      n_checks++; if (MemWData !== e_wdata) $display("[TB] FAIL rnd_memwdata c=%0d got %h want %h", c, MemWData, e_wdata); else n_pass++;
      n_checks++; if (IRData !== m_ir) $display("[TB] FAIL rnd_irdata c=%0d got %h want %h", c, IRData, m_ir); else n_pass++;
      n_checks++; if (DRData !== m_dr) $display("[TB] FAIL rnd_drdata c=%0d got %h want %h", c, DRData, m_dr); else n_pass++;
      n_checks++; if (IStall !== (IReq && !e_ir)) $display("[TB] FAIL rnd_istall c=%0d got %b want %b", c, IStall, (IReq && !e_ir)); else n_pass++;
      n_checks++; if (DStall !== (DReq && !e_dr)) $display("[TB] FAIL rnd_dstall c=%0d got %b want %b", c, DStall, (DReq && !e_dr)); else n_pass++;
      if (e_we) ref_mem[m_addr[11:2]] = m_wdata;
      if (Reset) begin
        m_grant = -1;
        m_ir    = 32'h0;
        m_dr    = 32'h0;
        m_last  = 1'b0;
      end else if (done_c) begin
        m_grant = -1;
      end else if (m_grant < 0 && (IReq || DReq)) begin
        if (IReq && DReq) begin
`ifdef MEMARB_RR_EN
          m_own = !m_last;
`else
          m_own = 1'b1;
`endif
        end else begin
          m_own = DReq;
        end
        m_grant = c;
        m_last  = m_own;
        m_wr    = m_own && DWrite;
        m_addr  = m_own ? DAddr : IAddr;
        m_wdata = (m_own && DWrite) ? DWData : 32'h0;
      end
      next_cycle();
      if (IReq) begin
        if (e_ir) begin
          if ($urandom_range(0, 1) == 0) IReq = 1'b0;
          else IAddr = rand_addr();
        end
      end else if ($urandom_range(0, 3) == 0) begin
        IReq  = 1'b1;
        IAddr = rand_addr();
      end
      if (DReq) begin
        if (e_dr) begin
          if ($urandom_range(0, 1) == 0) DReq = 1'b0;
          else begin
            DAddr  = rand_addr();
            DWrite = 1'($urandom_range(0, 1));
            DWData = $urandom;
          end
        end
      end else if ($urandom_range(0, 3) == 0) begin
        DReq   = 1'b1;
        DAddr  = rand_addr();
        DWrite = 1'($urandom_range(0, 1));
        DWData = $urandom;
      end
      Reset = ($urandom_range(0, 59) == 0);
    end
    Reset = 1'b0;
    settle();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    Reset    = 1'b1;
    IReq     = 1'b0;
    IAddr    = 32'h0;
    DReq     = 1'b0;
    DWrite   = 1'b0;
    DAddr    = 32'h0;
    DWData   = 32'h0;
    pre_we   = 1'b0;
    pre_clr  = 1'b1;
    pre_addr = 32'h0;
    pre_data = 32'h0;
    $display("[TB] starting mem_port_arbiter bench");
    test_reset();
    test_fetch();
    test_store();
    test_tie();
    test_load_use();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
